cpu_clk_enable_gen: RTL and testbench
=====================================

// Module: cpu_clk_enable_gen
// PURPOSE
// - Sits upstream of the CPU core and the cycle/phase LEDs. Turns the board clock, the step button and the
//   clkSel switches into a single-cycle clock-enable pulse cpuClkEn. It replaces the combinational clock mux,
//   so every downstream flop stays on clk.
// - Also keeps the 8-phase machine-cycle counter (cycle/sync), advanced only on enable pulses.
// PARAMETERS
// - DIV_1HZ      12000000  clk cycles per enable in mode 01 (>=2)
// - DIV_10HZ     1200000   clk cycles per enable in mode 10 (>=2)
// - DEBOUNCE_CYC 240000    consecutive stable samples needed to accept a button level change (>=1)
// - CNT_W        24        width of the divider and debounce counters; must hold DIV_1HZ-1
// PORTS
// - clk       in   1  board clock, all logic on rising edge
// - rst       in   1  asynchronous, active-high reset
// - clkBtnN   in   1  raw step button, active-low (0 = pressed), asynchronous
// - clkSel    in   2  mode: 00 step, 01 1 Hz, 10 10 Hz, 11 every clk; asynchronous
// - cpuClkEn  out  1  one-clk-wide enable pulse to the CPU core, registered
// - cycle     out  3  machine-cycle phase 0..7, registered
// - sync      out  1  high while cycle==7
// - modeOut   out  2  mode currently applied, registered
// BEHAVIOUR
// - Reset values (rst high, async): cpuClkEn=0, cycle=0, sync=0, modeOut=00.
//   Internal: debounced button=1, previous debounced=1, divider=0, debounce counter=0, all sync flops=1/00.
// - Synchronizers: clkBtnN and clkSel each pass through 2 flops before any use.
// - Debounce:
//   - Counter runs while the synced button differs from the debounced level and clears when they match.
//   - When the count reaches DEBOUNCE_CYC, the debounced level takes the synced value and the counter clears.
//   - Glitches shorter than DEBOUNCE_CYC are ignored.
// - Mode apply:
//   - When the synced clkSel differs from modeOut, modeOut loads it on the next edge.
//   - The same edge clears the divider and the press-edge history (previous debounced := current).
//   - cpuClkEn=0 on that edge whatever the old or new mode.
// - Enable generation (when no mode change is occurring):
//   - 00: pulse for one clk on a debounced 1->0 transition. Releasing the button and holding it give no pulse.
//     Latency is DEBOUNCE_CYC+3 edges from the first edge that samples clkBtnN low, if the button stays low.
//   - 01/10:
//     - Divider counts 0..DIV-1 and wraps to 0.
//     - cpuClkEn is registered high on the edge where the divider wraps, so the period is exactly DIV clks.
//     - The first pulse after a mode apply comes DIV clks after the apply edge.
//   - 11: cpuClkEn=1 on every edge after the apply edge.
//   - The divider holds at 0 in modes 00 and 11.
// - Phase counter:
//   - cycle increments mod 8 (7 wraps to 0) on each edge where cpuClkEn is currently high.
//   - sync = (cycle==7), combinational from the register.
// - Reset mid-operation:
//   - Pending debounce, divider progress and phase are discarded at once.
//   - After release, a button already held low produces a pulse (debounced starts at 1).
// - Simultaneous events: a mode change on the same edge as a divider wrap or a press edge takes priority.
//   That enable is dropped, not deferred.
// - No combinational path from any input to any output.
// TESTING (DIV_1HZ=10, DIV_10HZ=4, DEBOUNCE_CYC=3)
// - Reset, clkSel=00, button idle -> cpuClkEn=0, cycle=0, modeOut=00 for 50 clks.
// - Mode 00: press held 20 clks -> exactly one pulse, 6 edges after the first low sample.
//   A 2-clk glitch gives no pulse. 8 presses -> cycle returns to 0 and sync was high for the 8th press interval.
// - Mode 01: switch 00->01 -> modeOut=01 3 clks later. Pulses at apply+10, +20, +30. Period exactly 10.
// - Mode 10 then 11: 4-clk period. After switching to 11, no pulse on the apply edge, then continuous pulses.
//   cycle counts 0..7 and wraps.
// - Switch 01->10 on the divider wrap edge -> that pulse is suppressed and the next pulse comes 4 clks after apply.
// - Assert rst mid-debounce in mode 00 with the button held -> all outputs 0 at once.
//   After release, one pulse 6 edges after reset deassert.

Source files
------------

// File: rtl/cpu_clk_enable_gen_if.sv
// cpu_clk_enable_gen_if: board-side controls in, CPU clock-enable and phase outputs back.
//   clkBtnN  step button, active-low, asynchronous
//   clkSel   mode select: 00 step, 01 slow, 10 fast, 11 every clk
//   cpuClkEn one-clk enable pulse to the CPU core
//   cycle    machine-cycle phase 0..7
//   sync     high while cycle==7
//   modeOut  mode currently applied
interface cpu_clk_enable_gen_if;
  logic clkBtnN;
  logic [1:0] clkSel;
  logic cpuClkEn;
  logic [2:0] cycle;
  logic sync;
  logic [1:0] modeOut;
  modport master (output clkBtnN, clkSel, input cpuClkEn, cycle, sync, modeOut);
  modport slave (input clkBtnN, clkSel, output cpuClkEn, cycle, sync, modeOut);
endinterface

// File: rtl/cpu_clk_enable_gen.sv
// cpu_clk_enable_gen: single-cycle CPU clock-enable generator with debounced step button and 8-phase counter.
//   clk  board clock, rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of cpu_clk_enable_gen_if (clkBtnN, clkSel in; cpuClkEn, cycle, sync, modeOut out)
module cpu_clk_enable_gen #(
  parameter int DIV_1HZ = 12000000,
  parameter int DIV_10HZ = 1200000,
  parameter int DEBOUNCE_CYC = 240000,
  parameter int CNT_W = 24
) (
  input logic clk,
  input logic rst,
  cpu_clk_enable_gen_if.slave bus
);
  logic btnS1, btnS2, debounced, prevDeb, cpuClkEn;
  logic [1:0] selS1, selS2, modeOut;
  logic [2:0] cycle;
  logic [CNT_W-1:0] divCnt, dbCnt, divMax;
  logic modeChange, divWrap, dbDone, pressEdge, enNext;
  assign modeChange = selS2 != modeOut;
  assign divMax = modeOut == 2'b01 ? CNT_W'(DIV_1HZ - 1) : CNT_W'(DIV_10HZ - 1);
  assign divWrap = divCnt == divMax;
  assign dbDone = btnS2 != debounced && dbCnt == CNT_W'(DEBOUNCE_CYC - 1);
  assign pressEdge = prevDeb & ~debounced;
  // A mode change wins over every other enable source; the lost pulse is not deferred.
  always_comb enNext = modeChange ? 1'b0 : modeOut == 2'b00 ? pressEdge : modeOut == 2'b11 ? 1'b1 : divWrap;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      btnS1 <= 1'b1;
      btnS2 <= 1'b1;
      selS1 <= 2'b00;
      selS2 <= 2'b00;
      debounced <= 1'b1;
      prevDeb <= 1'b1;
      dbCnt <= '0;
      divCnt <= '0;
      modeOut <= 2'b00;
      cpuClkEn <= 1'b0;
      cycle <= 3'd0;
    end else begin
      btnS1 <= bus.clkBtnN;
      btnS2 <= btnS1;
      selS1 <= bus.clkSel;
      selS2 <= selS1;
      dbCnt <= (btnS2 == debounced || dbDone) ? '0 : dbCnt + CNT_W'(1);
      if (dbDone) debounced <= btnS2;
      // Tracking the current level every edge also clears any pending press edge on a mode apply.
      prevDeb <= debounced;
      modeOut <= selS2;
      // Divider only runs in the two divided modes and restarts from 0 on every apply.
      divCnt <= (modeChange || modeOut[0] == modeOut[1] || divWrap) ? '0 : divCnt + CNT_W'(1);
      cpuClkEn <= enNext;
      cycle <= cycle + {2'b00, cpuClkEn};
    end
  assign bus.cpuClkEn = cpuClkEn;
  assign bus.cycle = cycle;
  assign bus.sync = cycle == 3'd7;
  assign bus.modeOut = modeOut;
endmodule

// File: tb/tb_cpu_clk_enable_gen.sv
// tb_cpu_clk_enable_gen: directed and random stimulus against an edge-count reference model.
module tb_cpu_clk_enable_gen;
  localparam int D1 = 10, D10 = 4, DB = 3;
  logic clk = 1'b0, rst = 1'b1;
  cpu_clk_enable_gen_if bus ();
  cpu_clk_enable_gen #(.DIV_1HZ(D1), .DIV_10HZ(D10), .DEBOUNCE_CYC(DB), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, edgeNo = 0, pulses = 0, lastPulse = -1;
  int mRun, mSince, mMode, mSel1, mSel2, mCycle, mEn, mFell;
  logic mDeb, mBtn1, mBtn2;
  int start, p0, a;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mReset();
    mDeb = 1'b1; mBtn1 = 1'b1; mBtn2 = 1'b1; mRun = 0; mFell = 0;
    mSel1 = 0; mSel2 = 0; mMode = 0; mSince = 0; mEn = 0; mCycle = 0;
  endtask

  // Expected enable is derived from edges elapsed since the last mode apply and
  // from the run length of disagreeing button samples.
  task automatic tick();
    int div, newEn;
    @(posedge clk);
    edgeNo++;
    if (rst) mReset();
    else begin
      div = mMode == 1 ? D1 : D10;
      if (mSel2 != mMode) newEn = 0;
      else if (mMode == 0) newEn = mFell;
      else if (mMode == 3) newEn = 1;
      else newEn = ((mSince + 1) % div == 0) ? 1 : 0;
      mCycle = (mCycle + mEn) % 8;
      mEn = newEn;
      if (mSel2 != mMode) begin mMode = mSel2; mSince = 0; end
      else mSince++;
      mFell = 0;
      if (mBtn2 != mDeb) begin
        mRun++;
        if (mRun == DB) begin mFell = (mDeb && !mBtn2) ? 1 : 0; mDeb = mBtn2; mRun = 0; end
      end else mRun = 0;
      mBtn2 = mBtn1; mBtn1 = bus.clkBtnN;
      mSel2 = mSel1; mSel1 = int'(bus.clkSel);
    end
    #1;
    if (bus.cpuClkEn === 1'b1) begin pulses++; lastPulse = edgeNo; end
    check("cpuClkEn", {7'd0, bus.cpuClkEn}, 8'(mEn));
    check("cycle", {5'd0, bus.cycle}, 8'(mCycle));
    check("sync", {7'd0, bus.sync}, {7'd0, mCycle == 7});
    check("modeOut", {6'd0, bus.modeOut}, 8'(mMode));
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    check("rst_cpuClkEn", {7'd0, bus.cpuClkEn}, 8'd0);
    check("rst_cycle", {5'd0, bus.cycle}, 8'd0);
    check("rst_sync", {7'd0, bus.sync}, 8'd0);
    check("rst_modeOut", {6'd0, bus.modeOut}, 8'd0);
    mReset();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.clkBtnN = 1'b1; bus.clkSel = 2'b00; mReset();
    repeat (3) tick();
    rst = 1'b0;
    repeat (50) tick();
    check("idle_pulses", 8'(pulses), 8'd0);
    // held press: one pulse, six edges after the first low sample
    start = edgeNo; p0 = pulses; bus.clkBtnN = 1'b0;
    repeat (20) tick();
    check("press_count", 8'(pulses - p0), 8'd1);
    check("press_latency", 8'(lastPulse - start), 8'd6);
    bus.clkBtnN = 1'b1;
    repeat (10) tick();
    check("release_nopulse", 8'(pulses - p0), 8'd1);
    p0 = pulses; bus.clkBtnN = 1'b0;
    repeat (2) tick();
    bus.clkBtnN = 1'b1;
    repeat (10) tick();
    check("glitch_nopulse", 8'(pulses - p0), 8'd0);
    // eight presses from phase 0
    doReset();
    for (int i = 0; i < 8; i++) begin
      bus.clkBtnN = 1'b0; repeat (10) tick();
      bus.clkBtnN = 1'b1; repeat (10) tick();
      if (i == 6) check("sync_before_8th", {7'd0, bus.sync}, 8'd1);
    end
    check("cycle_wrap_8", {5'd0, bus.cycle}, 8'd0);
    // mode 01
    bus.clkSel = 2'b01; start = edgeNo; p0 = pulses;
    repeat (3) tick();
    check("mode01_apply", {6'd0, bus.modeOut}, 8'd1);
    a = edgeNo;
    for (int k = 1; k <= 3; k++) begin
      repeat (10) tick();
      check("mode01_pulse", 8'(lastPulse - a), 8'(10 * k));
    end
    check("mode01_count", 8'(pulses - p0), 8'd3);
    // mode 10 then 11
    bus.clkSel = 2'b10;
    repeat (3) tick();
    a = edgeNo; p0 = pulses;
    repeat (12) tick();
    check("mode10_count", 8'(pulses - p0), 8'd3);
    check("mode10_last", 8'(lastPulse - a), 8'd12);
    bus.clkSel = 2'b11;
    repeat (3) tick();
    check("mode11_apply_nopulse", {7'd0, bus.cpuClkEn}, 8'd0);
    p0 = pulses;
    repeat (10) tick();
    check("mode11_continuous", 8'(pulses - p0), 8'd10);
    // switch 01 -> 10 exactly on the divider wrap edge
    bus.clkSel = 2'b01;
    repeat (3) tick();
    a = edgeNo;
    repeat (7) tick();
    bus.clkSel = 2'b10; p0 = pulses;
    repeat (3) tick();
    check("wrap_apply_mode", {6'd0, bus.modeOut}, 8'd2);
    check("wrap_suppressed", 8'(pulses - p0), 8'd0);
    repeat (4) tick();
    check("wrap_next_pulse", 8'(lastPulse - (a + 10)), 8'd4);
    // reset mid-debounce with the button held
    bus.clkSel = 2'b00;
    repeat (20) tick();
    bus.clkBtnN = 1'b0;
    repeat (3) tick();
    doReset();
    start = edgeNo; p0 = pulses;
    repeat (12) tick();
    check("post_reset_count", 8'(pulses - p0), 8'd1);
    check("post_reset_latency", 8'(lastPulse - start), 8'd6);
    bus.clkBtnN = 1'b1;
    repeat (8) tick();
    // random soak
    for (int s = 0; s < 300; s++) begin
      bus.clkBtnN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.clkSel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) doReset();
      repeat ($urandom_range(1, 12)) tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
